// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and default constants for the program-counter generator.
//   pc_state_e    : RUN / HALT state encoding.
//   DEF_RESET_VEC : default PC after reset.
//   DEF_TRAP_VEC  : default PC loaded on a trap (or on a rejected misaligned redirect).
package pc_gen_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0180;

endpackage : pc_gen_pkg

// File: rtl/pc_gen_if.sv
// pc_gen_if: control/status bundle between the next-PC logic (master) and pc_gen (slave).
//   master drives : pc_wr, redir_valid, redir_target, trap, halt, resume
//   slave drives  : pc, npc_seq, halted, redir_pending, misalign_fault
interface pc_gen_if #(
    parameter int unsigned WIDTH = 32
);
    logic             pc_wr;
    logic             redir_valid;
    logic [WIDTH-1:0] redir_target;
    logic             trap;
    logic             halt;
    logic             resume;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] npc_seq;
    logic             halted;
    logic             redir_pending;
    logic             misalign_fault;

    modport master (
        output pc_wr, redir_valid, redir_target, trap, halt, resume,
        input  pc, npc_seq, halted, redir_pending, misalign_fault
    );

    modport slave (
        input  pc_wr, redir_valid, redir_target, trap, halt, resume,
        output pc, npc_seq, halted, redir_pending, misalign_fault
    );
endinterface : pc_gen_if

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC selection for pc_gen.
//   Inputs : current state, pc, request inputs, pending redirect register.
//   Outputs: pc_next, pend_clr (drop pending), pend_set (latch redir_target),
//            misalign (applied redirect rejected; only with PC_GEN_ALIGN_CHK_EN).
// Macro PC_GEN_ALIGN_CHK_EN: redirects whose low log2(INC) bits are nonzero are
// replaced by TRAP_VEC; without it targets load unmodified and misalign stays 0.
module pc_next_sel
    import pc_gen_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      INC      = 4,
    parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(DEF_TRAP_VEC)
) (
    input  pc_state_e        state,
    input  logic [WIDTH-1:0] pc,
    input  logic             pc_wr,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             trap,
    input  logic             halt,
    input  logic             pend_valid,
    input  logic [WIDTH-1:0] pend_target,
    output logic [WIDTH-1:0] pc_next,
    output logic             pend_clr,
    output logic             pend_set,
    output logic             misalign
);
`ifdef PC_GEN_ALIGN_CHK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 1);
`endif

    logic [WIDTH-1:0] tgt_s;

    // Priority selection of the next PC and pending-register action.
    always_comb begin
        pc_next  = pc;
        pend_clr = 1'b0;
        pend_set = 1'b0;
        misalign = 1'b0;
        tgt_s    = redir_target;
        case (state)
            ST_RUN: begin
                if (trap) begin
                    pc_next  = TRAP_VEC;
                    pend_clr = 1'b1;
                end else if (halt) begin
                    pend_set = redir_valid;
                end else if (pc_wr) begin
                    pend_clr = 1'b1;
                    if (redir_valid || pend_valid) begin
                        // A fresh redirect beats the older pending one.
                        tgt_s = redir_valid ? redir_target : pend_target;
`ifdef PC_GEN_ALIGN_CHK_EN
                        if ((tgt_s & ALIGN_MASK) != '0) begin
                            pc_next  = TRAP_VEC;
                            misalign = 1'b1;
                        end else begin
                            pc_next = tgt_s;
                        end
`else
                        pc_next = tgt_s;
`endif
                    end else begin
                        pc_next = pc + WIDTH'(INC);
                    end
                end else begin
                    pend_set = redir_valid;
                end
            end
            ST_HALT: begin
                if (trap) begin
                    pc_next  = TRAP_VEC;
                    pend_clr = 1'b1;
                end else begin
                    pend_set = redir_valid;
                end
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end
endmodule : pc_next_sel

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with stall, held redirect, trap and halt/resume.
//   clk, rst : clock; synchronous active-high reset.
//   bus      : pc_gen_if.slave (requests in; pc, npc_seq, halted,
//              redir_pending, misalign_fault out).
// Macro PC_GEN_ALIGN_CHK_EN enables misaligned-redirect rejection (see pc_next_sel).
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      INC       = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(DEF_TRAP_VEC)
) (
    input  logic     clk,
    input  logic     rst,
    pc_gen_if.slave  bus
);
    pc_state_e        state_r;
    pc_state_e        state_nxt_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_nxt_s;
    logic             pend_valid_r;
    logic [WIDTH-1:0] pend_tgt_r;
    logic             misalign_r;
    logic             pend_clr_s;
    logic             pend_set_s;
    logic             misalign_s;
    logic             halted_s;

    pc_next_sel #(
        .WIDTH    (WIDTH),
        .INC      (INC),
        .TRAP_VEC (TRAP_VEC)
    ) u_sel (
        .state        (state_r),
        .pc           (pc_r),
        .pc_wr        (bus.pc_wr),
        .redir_valid  (bus.redir_valid),
        .redir_target (bus.redir_target),
        .trap         (bus.trap),
        .halt         (bus.halt),
        .pend_valid   (pend_valid_r),
        .pend_target  (pend_tgt_r),
        .pc_next      (pc_nxt_s),
        .pend_clr     (pend_clr_s),
        .pend_set     (pend_set_s),
        .misalign     (misalign_s)
    );

    // State, PC and pending-redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_RUN;
            pc_r         <= RESET_VEC;
            pend_valid_r <= 1'b0;
            pend_tgt_r   <= '0;
            misalign_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            misalign_r <= misalign_s;
            if (pend_clr_s) begin
                pend_valid_r <= 1'b0;
            end else if (pend_set_s) begin
                pend_valid_r <= 1'b1;
                pend_tgt_r   <= bus.redir_target;
            end else begin
                pend_valid_r <= pend_valid_r;
            end
        end
    end

    // Next-state logic: trap always returns to RUN; resume beats halt in HALT.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (!bus.trap && bus.halt) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (bus.trap || bus.resume) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
            end
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        halted_s = 1'b0;
        if (state_r == ST_HALT) begin
            halted_s = 1'b1;
        end else begin
            halted_s = 1'b0;
        end
    end

    assign bus.pc             = pc_r;
    assign bus.npc_seq        = pc_r + WIDTH'(INC);
    assign bus.halted         = halted_s;
    assign bus.redir_pending  = pend_valid_r;
    assign bus.misalign_fault = misalign_r;
endmodule : pc_gen
